// File: rtl/perceptron_branch_predictor.sv
// Perceptron direction predictor for conditional branches at fetch.
// Speculative GHR, in-order pending queue, saturating weight training.
module perceptron_branch_predictor #(
  parameter int HIST_LEN      = 8,
  parameter int TABLE_ENTRIES = 256,
  parameter int WEIGHT_W      = 8,
  parameter int PEND_DEPTH    = 8,
  parameter int PC_W          = 32,
  parameter int THETA         = 29
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_predValid,
  input  logic [PC_W-1:0]             i_predPc,
  output logic                        o_predReady,
  output logic                        o_predValid,
  output logic                        o_predTaken,
  input  logic                        i_resolveValid,
  input  logic                        i_resolveTaken,
  output logic                        o_flush,
  output logic [$clog2(PEND_DEPTH):0] o_pendingCount
);

  localparam int IW = $clog2(TABLE_ENTRIES);
  localparam int PW = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CW = $clog2(PEND_DEPTH) + 1;
  localparam int SW = WEIGHT_W + $clog2(HIST_LEN + 1) + 1;
  localparam int NW = HIST_LEN + 1;

  localparam logic signed [WEIGHT_W-1:0] WMAX =
    {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] WMIN =
    {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [WEIGHT_W-1:0] WONE = WEIGHT_W'(1);

  // Row layout: [0] is the bias, [i+1] pairs with history bit i.
  logic signed [WEIGHT_W-1:0] w_q [TABLE_ENTRIES][NW];

  logic [HIST_LEN-1:0] ghr_q, ghr_d;

  logic [IW-1:0]       qidx_q  [PEND_DEPTH];
  logic                qtk_q   [PEND_DEPTH];
  logic [HIST_LEN-1:0] qsnap_q [PEND_DEPTH];
  logic                qlc_q   [PEND_DEPTH];
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       cnt_q;

  logic pv_q, pt_q, flush_q;

  logic [IW-1:0]        pidx;
  logic signed [SW-1:0] sum_c;
  logic [SW-1:0]        abs_c;
  logic                 taken_c, lowconf_c;

  logic [IW-1:0]       hidx;
  logic                htk, hlc;
  logic [HIST_LEN-1:0] hsnap;
  logic                pop_c, misp_c, train_c, acc_c;

  logic unused_pc;

  function automatic logic signed [SW-1:0] sx(
    input logic signed [WEIGHT_W-1:0] v
  );
    return {{(SW-WEIGHT_W){v[WEIGHT_W-1]}}, v};
  endfunction

  function automatic logic signed [WEIGHT_W-1:0] sat_step(
    input logic signed [WEIGHT_W-1:0] v,
    input logic                       up
  );
    logic signed [WEIGHT_W-1:0] r;
    r = v;
    if (up) begin
      if (v != WMAX) r = v + WONE;
    end else begin
      if (v != WMIN) r = v - WONE;
    end
    return r;
  endfunction

  assign pidx      = i_predPc[2 +: IW];
  assign unused_pc = ^{i_predPc[PC_W-1:2+IW], i_predPc[1:0]};

  // Dot product of the indexed row against the +/-1 history vector.
  always_comb begin
    sum_c = sx(w_q[pidx][0]);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (ghr_q[i]) sum_c = sum_c + sx(w_q[pidx][i+1]);
      else          sum_c = sum_c - sx(w_q[pidx][i+1]);
    end
  end

  assign taken_c   = ~sum_c[SW-1];
  assign abs_c     = sum_c[SW-1] ? -sum_c : sum_c;
  assign lowconf_c = (32'(abs_c) <= 32'(THETA));

  assign hidx  = qidx_q[head_q];
  assign htk   = qtk_q[head_q];
  assign hsnap = qsnap_q[head_q];
  assign hlc   = qlc_q[head_q];

  assign o_predReady = (cnt_q != CW'(PEND_DEPTH));
  assign pop_c   = i_resolveValid && (cnt_q != '0);
  assign misp_c  = pop_c && (i_resolveTaken != htk);
  assign train_c = pop_c && (misp_c || hlc);
  assign acc_c   = i_predValid && o_predReady && !misp_c;

  // History: restore from the mispredicted snapshot, else shift in guess.
  always_comb begin
    ghr_d = ghr_q;
    if (misp_c)     ghr_d = HIST_LEN'({hsnap, i_resolveTaken});
    else if (acc_c) ghr_d = HIST_LEN'({ghr_q, taken_c});
  end

  // Global history register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ghr_q <= '0;
    else          ghr_q <= ghr_d;
  end

  // Saturating training of the resolved branch's row.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < TABLE_ENTRIES; r++)
        for (int k = 0; k < NW; k++)
          w_q[r][k] <= '0;
    end else if (train_c) begin
      w_q[hidx][0] <= sat_step(w_q[hidx][0], i_resolveTaken);
      for (int i = 0; i < HIST_LEN; i++)
        w_q[hidx][i+1] <= sat_step(w_q[hidx][i+1],
                                   hsnap[i] == i_resolveTaken);
    end
  end

  // Pending queue: push on accept, pop on resolve, clear on mispredict.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int j = 0; j < PEND_DEPTH; j++) begin
        qidx_q[j]  <= '0;
        qtk_q[j]   <= 1'b0;
        qsnap_q[j] <= '0;
        qlc_q[j]   <= 1'b0;
      end
    end else if (misp_c) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (acc_c) begin
        qidx_q[tail_q]  <= pidx;
        qtk_q[tail_q]   <= taken_c;
        qsnap_q[tail_q] <= ghr_q;
        qlc_q[tail_q]   <= lowconf_c;
        tail_q          <= tail_q + PW'(1);
      end
      if (pop_c) head_q <= head_q + PW'(1);
      cnt_q <= cnt_q + CW'(acc_c) - CW'(pop_c);
    end
  end

  // Registered prediction result and flush pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pv_q    <= 1'b0;
      pt_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pv_q    <= acc_c;
      pt_q    <= acc_c & taken_c;
      flush_q <= misp_c;
    end
  end

  assign o_predValid    = pv_q;
  assign o_predTaken    = pt_q;
  assign o_flush        = flush_q;
  assign o_pendingCount = cnt_q;

endmodule
